// File: rtl/xbar_route_arbiter_if.sv
// ---------------------------------------------------------------------------
// xbar_route_arbiter_if
//   Bundles the signals between the input queues, the route arbiter and the
//   crossbar's control/recv ports.
//   slave  : arbiter side (reads sources/crossbar, drives gated val/rdy,
//            control word, grant status and timeout).
//   master : environment side (input queues + crossbar).
//   Signals:
//     in_msg[N_INPUTS]  source messages, dest field in the top OW bits
//     in_val / in_rdy   source handshake (in_rdy is the gated recv_rdy)
//     xb_val / xb_rdy   crossbar recv handshake (xb_val is the gated in_val)
//     control*          route word and its handshake
//     grant_val/id      current grant status
//     timeout           one-cycle stall abort pulse
// ---------------------------------------------------------------------------
interface xbar_route_arbiter_if #(
    parameter int BIT_WIDTH         = 32,
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42
);
    localparam int IW = $clog2(N_INPUTS);

    logic [BIT_WIDTH-1:0]         in_msg [N_INPUTS];
    logic [N_INPUTS-1:0]          in_val;
    logic [N_INPUTS-1:0]          in_rdy;
    logic [N_INPUTS-1:0]          xb_val;
    logic [N_INPUTS-1:0]          xb_rdy;
    logic [CONTROL_BIT_WIDTH-1:0] control;
    logic                         control_val;
    logic                         control_rdy;
    logic                         grant_val;
    logic [IW-1:0]                grant_id;
    logic                         timeout;

    modport slave (
        input  in_msg, in_val, xb_rdy, control_rdy,
        output in_rdy, xb_val, control, control_val, grant_val, grant_id, timeout
    );

    modport master (
        output in_msg, in_val, xb_rdy, control_rdy,
        input  in_rdy, xb_val, control, control_val, grant_val, grant_id, timeout
    );
endinterface

// File: rtl/xbar_route_arbiter.sv
// ---------------------------------------------------------------------------
// xbar_route_arbiter
//   Round-robin scheduler sharing one crossbar route among N_INPUTS sources.
//   IDLE picks the first eligible input starting at rr_ptr, CFG hands the
//   route word to the crossbar, XFER passes PKT_LEN beats of the granted
//   input only, then the route is released via one IDLE cycle.
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    xbar_route_arbiter_if.slave (sources, crossbar, control, status)
// Configuration:
//   XBAR_ARB_TIMEOUT_EN  when defined, a granted input that stalls for
//                        TIMEOUT_CYCLES consecutive XFER cycles is aborted
//                        (timeout pulse, turn passed on). Undefined: XFER waits
//                        indefinitely and timeout is tied low.
// ---------------------------------------------------------------------------
module xbar_route_arbiter #(
    parameter int BIT_WIDTH         = 32,
    parameter int N_INPUTS          = 2,
    parameter int N_OUTPUTS         = 2,
    parameter int CONTROL_BIT_WIDTH = 42,
    parameter int PKT_LEN           = 4,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input logic                  clk,
    input logic                  reset,
    xbar_route_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N_INPUTS);
    localparam int OW = $clog2(N_OUTPUTS);
    localparam int CW = CONTROL_BIT_WIDTH;
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    if (N_INPUTS < 2 || N_OUTPUTS < 2 || PKT_LEN < 1 || TIMEOUT_CYCLES < 1 || CW < IW + OW)
    begin : g_param_check
        $error("xbar_route_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, CFG, XFER} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   control_q, control_d;
    logic            control_val_q, control_val_d;
    logic            timeout_q, timeout_d;
`ifdef XBAR_ARB_TIMEOUT_EN
    localparam int SW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
`endif

    logic [N_INPUTS-1:0] elig;
    logic                any_elig;
    logic [IW-1:0]       win_id;
    logic [OW-1:0]       win_dest;
    int                  idx;
    logic [IW-1:0]       next_ptr;
    logic                fire;
    logic [N_INPUTS-1:0] xb_val_c, in_rdy_c;
    logic                unused_payload;

    // Eligible: valid and header names an existing output.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_INPUTS; i++)
            elig[i] = bus.in_val[i] && (int'(bus.in_msg[i][BIT_WIDTH-1 -: OW]) < N_OUTPUTS);
    end

    // Payload bits below the dest field go straight to the crossbar; folding
    // them here keeps the whole message visibly consumed.
    always_comb begin
        unused_payload = 1'b0;
        for (int i = 0; i < N_INPUTS; i++)
            unused_payload = unused_payload ^ (^bus.in_msg[i]);
    end

    // Scan from the far end back to offset 0 so the input closest to rr_ptr
    // is the last writer and therefore the winner.
    always_comb begin
        any_elig = 1'b0;
        win_id   = '0;
        idx      = 0;
        for (int k = N_INPUTS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_q) + k) % N_INPUTS;
            if (elig[idx]) begin
                any_elig = 1'b1;
                win_id   = IW'(idx);
            end
        end
        win_dest = bus.in_msg[win_id][BIT_WIDTH-1 -: OW];
    end

    // Explicit wrap keeps non-power-of-2 N_INPUTS inside the legal range.
    assign next_ptr = (grant_id_q == IW'(N_INPUTS - 1)) ? '0 : grant_id_q + IW'(1);

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;
        control_d     = control_q;
        control_val_d = control_val_q;
        timeout_d     = 1'b0;
        xb_val_c      = '0;
        in_rdy_c      = '0;
        fire          = 1'b0;
`ifdef XBAR_ARB_TIMEOUT_EN
        stall_cnt_d   = stall_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    grant_id_d                   = win_id;
                    control_d                    = '0;
                    control_d[CW-1 -: IW]        = win_id;
                    control_d[CW-IW-1 -: OW]     = win_dest;
                    control_val_d                = 1'b1;
                    state_d                      = CFG;
                end
            end
            CFG: begin
                // The crossbar latches the word on this edge, so data may
                // flow from the very first XFER cycle.
                if (bus.control_rdy) begin
                    control_val_d = 1'b0;
                    beat_cnt_d    = '0;
                    state_d       = XFER;
`ifdef XBAR_ARB_TIMEOUT_EN
                    stall_cnt_d   = '0;
`endif
                end
            end
            XFER: begin
                xb_val_c[grant_id_q] = bus.in_val[grant_id_q];
                in_rdy_c[grant_id_q] = bus.xb_rdy[grant_id_q];
                fire = bus.in_val[grant_id_q] && bus.xb_rdy[grant_id_q];
                if (fire) begin
                    if (beat_cnt_q == BW'(PKT_LEN - 1)) begin
                        state_d    = IDLE;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BW'(1);
                    end
`ifdef XBAR_ARB_TIMEOUT_EN
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == SW'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled source forfeits its turn.
                    timeout_d   = 1'b1;
                    state_d     = IDLE;
                    rr_ptr_d    = next_ptr;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous); a reset in the
    // middle of a packet simply drops it with no cleanup handshake.
    // NOTE: state registers use non-blocking assignments so all of them update
    // together from the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            beat_cnt_q    <= '0;
            control_q     <= '0;
            control_val_q <= 1'b0;
            timeout_q     <= 1'b0;
`ifdef XBAR_ARB_TIMEOUT_EN
            stall_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            beat_cnt_q    <= beat_cnt_d;
            control_q     <= control_d;
            control_val_q <= control_val_d;
            timeout_q     <= timeout_d;
`ifdef XBAR_ARB_TIMEOUT_EN
            stall_cnt_q   <= stall_cnt_d;
`endif
        end
    end

    assign bus.control     = control_q;
    assign bus.control_val = control_val_q;
    assign bus.grant_val   = (state_q == XFER);
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout     = timeout_q;
    assign bus.xb_val      = xb_val_c;
    assign bus.in_rdy      = in_rdy_c;
endmodule

// File: tb/tb_xbar_route_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xbar_route_arbiter
//   Directed bench for xbar_route_arbiter with default parameters
//   (N_INPUTS=2, N_OUTPUTS=2, CW=42, PKT_LEN=4, TIMEOUT_CYCLES=16).
//   Dest field is msg[31]; control[41]=grant_id, control[40]=dest.
// ---------------------------------------------------------------------------
module tb_xbar_route_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    xbar_route_arbiter_if #(
        .BIT_WIDTH(32), .N_INPUTS(2), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(42)
    ) bus ();

    xbar_route_arbiter #(
        .BIT_WIDTH(32), .N_INPUTS(2), .N_OUTPUTS(2), .CONTROL_BIT_WIDTH(42),
        .PKT_LEN(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        bus.in_val      = '0;
        bus.xb_rdy      = '0;
        bus.control_rdy = 1'b0;
        bus.in_msg[0]   = '0;
        bus.in_msg[1]   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.control, bus.grant_id, bus.timeout} !== 44'h0) begin
            n_fail++; $display("FAIL reset_regs: got control=%h id=%b to=%b, want all 0",
                               bus.control, bus.grant_id, bus.timeout);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({bus.control_val, bus.grant_val, bus.xb_val, bus.in_rdy} !== 6'b0) begin
                n_fail++; $display("FAIL reset_idle c%0d: got cv=%b gv=%b xv=%b ir=%b, want 0",
                                   c, bus.control_val, bus.grant_val, bus.xb_val, bus.in_rdy);
            end
        end
    endtask

    task automatic test_single_packet();
        do_reset();
        bus.in_msg[0] = 32'h8000_0011;
        bus.in_val    = 2'b01;
        bus.xb_rdy    = 2'b11;
        step();
        n_checks++;
        if (bus.control_val !== 1'b1) begin
            n_fail++; $display("FAIL single_cval: got %b want 1", bus.control_val);
        end
        n_checks++;
        if (bus.control[41:40] !== 2'b01) begin
            n_fail++; $display("FAIL single_ctrl: got %b want 01", bus.control[41:40]);
        end
        n_checks++;
        if ({bus.grant_val, bus.xb_val, bus.in_rdy} !== 5'b0) begin
            n_fail++; $display("FAIL single_cfg_gate: got gv=%b xv=%b ir=%b want 0",
                               bus.grant_val, bus.xb_val, bus.in_rdy);
        end
        bus.control_rdy = 1'b1;
        step();
        bus.control_rdy = 1'b0;
        n_checks++;
        if ({bus.control_val, bus.grant_id} !== 2'b00) begin
            n_fail++; $display("FAIL single_handshake: got cv=%b id=%b want 0 0",
                               bus.control_val, bus.grant_id);
        end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if ({bus.grant_val, bus.xb_val, bus.in_rdy} !== 5'b1_01_01) begin
                n_fail++; $display("FAIL single_beat%0d: got gv=%b xv=%b ir=%b want 1 01 01",
                                   b, bus.grant_val, bus.xb_val, bus.in_rdy);
            end
            step();
        end
        n_checks++;
        if ({bus.grant_val, bus.xb_val, bus.in_rdy} !== 5'b0) begin
            n_fail++; $display("FAIL single_release: got gv=%b xv=%b ir=%b want 0",
                               bus.grant_val, bus.xb_val, bus.in_rdy);
        end
        bus.in_val = 2'b00;
    endtask

    task automatic test_round_robin();
        logic       exp_id;
        logic [1:0] exp_vec;
        int         wait_cyc;
        int         len;
        do_reset();
        bus.in_msg[0]   = 32'h8000_0000;  // dest 1
        bus.in_msg[1]   = 32'h0000_0000;  // dest 0
        bus.in_val      = 2'b11;
        bus.xb_rdy      = 2'b11;
        bus.control_rdy = 1'b1;
        for (int p = 0; p < 4; p++) begin
            exp_id  = p[0];
            exp_vec = exp_id ? 2'b10 : 2'b01;
            wait_cyc = 0;
            while (bus.grant_val !== 1'b1 && wait_cyc < 20) begin
                step();
                wait_cyc++;
            end
            n_checks++;
            if (wait_cyc != 2) begin
                n_fail++; $display("FAIL rr_latency p%0d: got %0d cycles want 2", p, wait_cyc);
            end
            n_checks++;
            if ({bus.grant_id, bus.control[41:40]} !== {exp_id, exp_id, ~exp_id}) begin
                n_fail++; $display("FAIL rr_grant p%0d: got id=%b ctl=%b want id=%b ctl=%b",
                                   p, bus.grant_id, bus.control[41:40], exp_id, {exp_id, ~exp_id});
            end
            len = 0;
            while (bus.grant_val === 1'b1 && len < 20) begin
                n_checks++;
                if ({bus.xb_val, bus.in_rdy} !== {exp_vec, exp_vec}) begin
                    n_fail++; $display("FAIL rr_gate p%0d: got xv=%b ir=%b want %b",
                                       p, bus.xb_val, bus.in_rdy, exp_vec);
                end
                len++;
                step();
            end
            n_checks++;
            if (len != 4) begin
                n_fail++; $display("FAIL rr_len p%0d: got %0d beats want 4", p, len);
            end
        end
        bus.in_val = 2'b00;
    endtask

    task automatic test_cfg_stall();
        do_reset();
        bus.in_msg[0] = 32'h8000_0000;
        bus.in_val    = 2'b01;
        bus.xb_rdy    = 2'b11;
        step();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if ({bus.control_val, bus.control, bus.grant_val, bus.xb_val, bus.in_rdy}
                !== {1'b1, 42'h100_0000_0000, 1'b0, 2'b00, 2'b00}) begin
                n_fail++; $display("FAIL cfg_hold c%0d: got cv=%b ctl=%h gv=%b xv=%b ir=%b",
                                   c, bus.control_val, bus.control, bus.grant_val,
                                   bus.xb_val, bus.in_rdy);
            end
            step();
        end
        bus.control_rdy = 1'b1;
        #1;
        n_checks++;
        if (bus.grant_val !== 1'b0) begin
            n_fail++; $display("FAIL cfg_early: got gv=%b want 0", bus.grant_val);
        end
        step();
        bus.control_rdy = 1'b0;
        n_checks++;
        if ({bus.grant_val, bus.xb_val} !== 3'b1_01) begin
            n_fail++; $display("FAIL cfg_xfer: got gv=%b xv=%b want 1 01", bus.grant_val, bus.xb_val);
        end
    endtask

    task automatic test_backpressure_and_reset();
        logic rdy0;
        do_reset();
        bus.in_msg[0]   = 32'h8000_0000;
        bus.in_val      = 2'b01;
        bus.control_rdy = 1'b1;
        step();
        step();
        // xb_rdy pattern 1,0,1,0,1,0,1 -> 4 fires over 7 XFER cycles.
        for (int k = 0; k < 7; k++) begin
            rdy0       = (k % 2 == 0);
            bus.xb_rdy = {1'b0, rdy0};
            #1;
            n_checks++;
            if ({bus.grant_val, bus.in_rdy} !== {1'b1, 1'b0, rdy0}) begin
                n_fail++; $display("FAIL bp_k%0d: got gv=%b ir=%b want 1 0%b",
                                   k, bus.grant_val, bus.in_rdy, rdy0);
            end
            step();
        end
        n_checks++;
        if (bus.grant_val !== 1'b0) begin
            n_fail++; $display("FAIL bp_count: got gv=%b after 4 fires, want 0", bus.grant_val);
        end
        // Second packet on input 1, reset while in beat 2.
        do_reset();
        bus.in_msg[1]   = 32'h8000_0000;
        bus.in_val      = 2'b10;
        bus.xb_rdy      = 2'b11;
        bus.control_rdy = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.grant_val, bus.grant_id, bus.control[41:40]} !== 4'b1_1_11) begin
            n_fail++; $display("FAIL rst_pre: got gv=%b id=%b ctl=%b want 1 1 11",
                               bus.grant_val, bus.grant_id, bus.control[41:40]);
        end
        step();
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.control_val, bus.grant_val, bus.grant_id, bus.control, bus.timeout,
             bus.xb_val, bus.in_rdy} !== 50'h0) begin
            n_fail++; $display("FAIL rst_mid: got cv=%b gv=%b id=%b ctl=%h to=%b xv=%b ir=%b, want 0",
                               bus.control_val, bus.grant_val, bus.grant_id, bus.control,
                               bus.timeout, bus.xb_val, bus.in_rdy);
        end
        reset = 1'b0;
    endtask

    task automatic test_stall_timeout();
        int n;
        do_reset();
        bus.in_msg[0]   = 32'h8000_0000;
        bus.in_msg[1]   = 32'h0000_0000;
        bus.in_val      = 2'b11;
        bus.xb_rdy      = 2'b11;
        bus.control_rdy = 1'b1;
        step();
        step();
        bus.in_val = 2'b10;  // granted input 0 goes quiet
        n = 0;
        while (bus.grant_val === 1'b1 && bus.timeout === 1'b0 && n < 40) begin
            step();
            n++;
        end
`ifdef XBAR_ARB_TIMEOUT_EN
        n_checks++;
        if (n != 16 || bus.timeout !== 1'b1 || bus.grant_val !== 1'b0) begin
            n_fail++; $display("FAIL to_pulse: got n=%0d to=%b gv=%b want 16 1 0",
                               n, bus.timeout, bus.grant_val);
        end
        step();
        n_checks++;
        if ({bus.timeout, bus.control_val, bus.control[41:40]} !== 4'b0_1_10) begin
            n_fail++; $display("FAIL to_rearb: got to=%b cv=%b ctl=%b want 0 1 10",
                               bus.timeout, bus.control_val, bus.control[41:40]);
        end
        step();
        n_checks++;
        if ({bus.grant_val, bus.grant_id, bus.xb_val} !== 4'b1_1_10) begin
            n_fail++; $display("FAIL to_next: got gv=%b id=%b xv=%b want 1 1 10",
                               bus.grant_val, bus.grant_id, bus.xb_val);
        end
`else
        n_checks++;
        if (n != 40 || {bus.grant_val, bus.grant_id, bus.timeout, bus.xb_val} !== 5'b1_0_0_00) begin
            n_fail++; $display("FAIL no_to: got n=%0d gv=%b id=%b to=%b xv=%b want 40 1 0 0 00",
                               n, bus.grant_val, bus.grant_id, bus.timeout, bus.xb_val);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_cfg_stall();
        test_backpressure_and_reset();
        test_stall_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
